// File: rtl/red_pkg.sv
// Shared encodings for the bit-serial comparison sequencer: FSM states and
// comparison-mode constants.
package red_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam logic MODO_MAYOR = 1'b0;  // A > B
  localparam logic MODO_IGUAL = 1'b1;  // A == B

endpackage

// File: rtl/celda_serie_d_i.sv
// Single reusable comparison cell of the right-to-left iterative network.
// The first cell has no incoming partial result; later cells chain through p_in.
module celda_serie_d_i
  import red_pkg::*;
(
  input  logic a_p,
  input  logic b_p,
  input  logic p_in,
  input  logic primera,
  input  logic modo,
  output logic p_x
);

  logic gt_bit;
  logic eq_bit;

  always_comb begin
    gt_bit = a_p & ~b_p;
    eq_bit = ~(a_p ^ b_p);
    p_x    = 1'b0;
    if (primera) begin
      p_x = (modo == MODO_IGUAL) ? eq_bit : gt_bit;
    end else if (modo == MODO_IGUAL) begin
      p_x = eq_bit & p_in;
    end else begin
      // Higher bit decides when it differs; otherwise keep the lower-bit verdict.
      p_x = gt_bit | (eq_bit & p_in);
    end
  end

endmodule

// File: rtl/red_secuencial_d_i.sv
// Bit-serial N-bit unsigned comparator (A > B or A == B), one bit per clock
// from LSB to MSB, with start/busy/done handshake and a held result Z.
module red_secuencial_d_i
  import red_pkg::*;
#(
  parameter int unsigned N = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         modo,
  input  logic [N-1:0] palabraA,
  input  logic [N-1:0] palabraB,
  output logic         busy,
  output logic         done,
  output logic         Z
);

  localparam int unsigned IW = $clog2(N);
  localparam logic [IW-1:0] ILast = IW'(N - 1);

  state_e        state_q, state_d;
  logic [IW-1:0] i_q, i_d;
  logic          p_q, p_d;
  logic          z_q, z_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic          modo_q, modo_d;
  logic          p_x;

  celda_serie_d_i u_celda (
    .a_p    (a_q[i_q]),
    .b_p    (b_q[i_q]),
    .p_in   (p_q),
    .primera(i_q == '0),
    .modo   (modo_q),
    .p_x    (p_x)
  );

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    p_d     = p_q;
    z_d     = z_q;
    a_d     = a_q;
    b_d     = b_q;
    modo_d  = modo_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = palabraA;
          b_d     = palabraB;
          modo_d  = modo;
          i_d     = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        p_d = p_x;
        if (i_q == ILast) begin
          // Z only moves here, so intermediate bits never show on the output.
          z_d     = p_x;
          i_d     = '0;
          state_d = StDone;
        end else begin
          i_d = i_q + IW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      i_q     <= '0;
      p_q     <= 1'b0;
      z_q     <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      modo_q  <= MODO_MAYOR;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      p_q     <= p_d;
      z_q     <= z_d;
      a_q     <= a_d;
      b_q     <= b_d;
      modo_q  <= modo_d;
    end
  end

  assign busy = (state_q == StRun) || (state_q == StDone);
  assign done = (state_q == StDone);
  assign Z    = z_q;

endmodule

// File: doc/red_secuencial_d_i.md
# red_secuencial_d_i

Bit-serial sequencer for the right-to-left iterative comparison network. It evaluates an N-bit unsigned comparison between two words one bit position per clock, from bit 0 to bit N-1, using a single reusable comparison cell. It also owns the start/busy/done handshake toward the surrounding control logic, and holds the result Z stable until the next operation.

## Interface
- N, default 3: word width in bits; legal range 2..16.
- clk, input, 1: rising-edge clock.
- reset, input, 1: asynchronous, active-high reset.
- start, input, 1: request a comparison; sampled only in IDLE.
- modo, input, 1: comparison type; 0 computes A > B, 1 computes A == B. Latched with the operands.
- palabraA, input, N: operand A; latched on an accepted start.
- palabraB, input, N: operand B; latched on an accepted start.
- busy, output, 1: high in RUN and DONE.
- done, output, 1: one-cycle pulse when Z is updated.
- Z, output, 1: comparison result; holds its value between operations.

## Operation
- FSM states: IDLE, RUN, DONE. All flops reset asynchronously to the following values:
  - state = IDLE
  - bit index i = 0
  - partial result p = 0
  - Z = 0, done = 0, busy = 0
- IDLE with start=1:
  - latch palabraA, palabraB and modo into shadow registers.
  - set i=0, go to RUN.
- IDLE with start=0: stay in IDLE; all outputs hold.
- RUN: each cycle, feed bit i of both shadow operands and the current p to the comparison cell, then write the cell output to p.
  - Cell at i=0 (initial cell):
    - modo=0: p = a & ~b
    - modo=1: p = ~(a ^ b)
  - Cell at i>0 (typical/final cell):
    - modo=0: p = (a & ~b) | (~(a ^ b) & p)
    - modo=1: p = ~(a ^ b) & p
  - If i = N-1: write the cell output directly to Z, go to DONE. Otherwise increment i.
- DONE: done=1 for this cycle only, then go to IDLE unconditionally.
- start in RUN or DONE is ignored. It is not queued, and the shadow operands are not updated.
- Changes on palabraA, palabraB or modo after acceptance do not affect the operation in flight.
- The index counter is ceil(log2(N)) bits wide and never wraps past N-1.

## Timing
- Cycle numbering: start is accepted at edge 0.
- Bit k is processed at edge k+1.
- Z is updated at edge N, and done is high during the cycle after edge N.
- Total latency from accepted start to done is N+1 cycles. For N=3, done is high in cycle 4.
- busy rises the cycle after acceptance and falls together with done.
- Back-to-back operation: start held high in the cycle after done is accepted.
  - Minimum issue interval is N+2 cycles.
- Reset mid-operation: return to IDLE immediately with Z=0, done=0, busy=0. The partial result is discarded.
- Z changes only at the final RUN edge or on reset. It is never glitched by intermediate bits.

## Structure
- Shared package red_pkg contains:
  - the FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2)
  - the modo constants MODO_MAYOR=1'b0 and MODO_IGUAL=1'b1
- One sub-module: celda_serie_d_i. It is combinational and has these ports:
  - a_p, b_p, p_in, primera, modo inputs
  - p_x output
- The sequencer instantiates celda_serie_d_i once and drives primera = (i == 0).

## Test plan
- N=3, modo=0, A=3'b101, B=3'b011, start for one cycle -> busy high for cycles 1–4, done pulse in cycle 4, Z=1.
- N=3, modo=0, A=3'b010, B=3'b010 -> Z=0; then modo=1, same operands -> Z=1, and Z holds between the two operations.
- N=3, modo=1, A=3'b110, B=3'b111 (differ only at bit 0) -> Z=0.
- Same operation, start pulsed in cycles 2 and 3 while operands change to A=0, B=7 -> ignored; result Z=0 at cycle 4 reflects the original operands.
- Assert reset in cycle 2 of an operation -> Z=0, busy=0, done=0 immediately, and no done pulse follows. A new start after reset completes normally.
- N=8, modo=0, A=8'h80, B=8'h7F, with start held high continuously -> done every 10 cycles, Z=1 each time.
